// File: rtl/video_timing_gen_if.sv
// Raster timing bus from video_timing_gen to the TMDS encoders and pixel source.
// Optional member o_rgb exists only when VIDEO_TIMING_TEST_PATTERN_EN is defined.
interface video_timing_gen_if #(
    parameter int XW = 10,
    parameter int YW = 10
) ();
    logic          i_en;
    logic          o_hsync;
    logic          o_vsync;
    logic [1:0]    o_control_data;
    logic          o_blanking;
    logic          o_active;
    logic [XW-1:0] o_x;
    logic [YW-1:0] o_y;
    logic          o_line_start;
    logic          o_frame_start;
`ifdef VIDEO_TIMING_TEST_PATTERN_EN
    logic [23:0]   o_rgb;

    modport master (
        input  i_en,
        output o_hsync, o_vsync, o_control_data, o_blanking, o_active,
               o_x, o_y, o_line_start, o_frame_start, o_rgb
    );
    modport slave (
        output i_en,
        input  o_hsync, o_vsync, o_control_data, o_blanking, o_active,
               o_x, o_y, o_line_start, o_frame_start, o_rgb
    );
`else
    modport master (
        input  i_en,
        output o_hsync, o_vsync, o_control_data, o_blanking, o_active,
               o_x, o_y, o_line_start, o_frame_start
    );
    modport slave (
        output i_en,
        input  o_hsync, o_vsync, o_control_data, o_blanking, o_active,
               o_x, o_y, o_line_start, o_frame_start
    );
`endif
endinterface

// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel/line counters with registered sync, blanking,
// coordinate and strobe outputs. Outputs carry the decode of the counter values
// held before each enabled edge, so pixel (x,y) appears one enabled edge later.
// Optional colour-bar pattern on o_rgb: define VIDEO_TIMING_TEST_PATTERN_EN.
module video_timing_gen #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int H_SYNC_POL = 0,
    parameter int V_SYNC_POL = 0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    video_timing_gen_if.master vif
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int XW      = $clog2(H_TOTAL);
    localparam int YW      = $clog2(V_TOTAL);

    localparam logic [XW-1:0] H_LAST   = XW'(H_TOTAL - 1);
    localparam logic [YW-1:0] V_LAST   = YW'(V_TOTAL - 1);
    localparam logic [XW-1:0] H_ACT_N  = XW'(H_ACTIVE);
    localparam logic [YW-1:0] V_ACT_N  = YW'(V_ACTIVE);
    localparam logic [XW-1:0] HS_START = XW'(H_ACTIVE + H_FP);
    localparam logic [XW-1:0] HS_END   = XW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [YW-1:0] VS_START = YW'(V_ACTIVE + V_FP);
    localparam logic [YW-1:0] VS_END   = YW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic          HS_ON    = (H_SYNC_POL != 0) ? 1'b1 : 1'b0;
    localparam logic          VS_ON    = (V_SYNC_POL != 0) ? 1'b1 : 1'b0;

    // Reject degenerate timings at elaboration.
    if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1) begin : g_bad_h
        $error("video_timing_gen: horizontal timing parameters must all be >= 1");
    end
    if (V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_v
        $error("video_timing_gen: vertical timing parameters must all be >= 1");
    end

    // Map an asserted/deasserted sync condition to the configured pin level.
    function automatic logic sync_level(input logic asserted, input logic on_level);
        return asserted ? on_level : ~on_level;
    endfunction

    logic [XW-1:0] h_cnt_q, h_cnt_d;
    logic [YW-1:0] v_cnt_q, v_cnt_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          blanking_q, blanking_d;
    logic          active_q, active_d;
    logic          line_start_q, line_start_d;
    logic          frame_start_q, frame_start_d;
    logic          h_vis_s, v_vis_s, h_sync_s, v_sync_s;

`ifdef VIDEO_TIMING_TEST_PATTERN_EN
    localparam int BAR_W = (H_ACTIVE / 8 > 0) ? (H_ACTIVE / 8) : 1;

    // Colour of the vertical bar containing horizontal position c.
    function automatic logic [23:0] bar_colour(input logic [XW-1:0] c);
        int unsigned bar;
        bar = 32'(c) / 32'(BAR_W);
        case (bar)
            32'd0:   return 24'hFFFFFF;
            32'd1:   return 24'hFFFF00;
            32'd2:   return 24'h00FFFF;
            32'd3:   return 24'h00FF00;
            32'd4:   return 24'hFF00FF;
            32'd5:   return 24'hFF0000;
            32'd6:   return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    logic [23:0] rgb_q, rgb_d;
`endif

    // Region decode of the current counter values.
    always_comb begin
        h_vis_s  = (h_cnt_q < H_ACT_N);
        v_vis_s  = (v_cnt_q < V_ACT_N);
        h_sync_s = (h_cnt_q >= HS_START) && (h_cnt_q < HS_END);
        v_sync_s = (v_cnt_q >= VS_START) && (v_cnt_q < VS_END);
    end

    // Counter advance and output decode; everything holds except the strobes when disabled.
    always_comb begin
        h_cnt_d       = h_cnt_q;
        v_cnt_d       = v_cnt_q;
        x_d           = x_q;
        y_d           = y_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        blanking_d    = blanking_q;
        active_d      = active_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
`ifdef VIDEO_TIMING_TEST_PATTERN_EN
        rgb_d         = rgb_q;
`endif
        if (vif.i_en) begin
            x_d           = h_cnt_q;
            y_d           = v_cnt_q;
            hsync_d       = sync_level(h_sync_s, HS_ON);
            vsync_d       = sync_level(v_sync_s, VS_ON);
            blanking_d    = ~(h_vis_s && v_vis_s);
            active_d      = h_vis_s && v_vis_s;
            line_start_d  = (h_cnt_q == {XW{1'b0}});
            frame_start_d = (h_cnt_q == {XW{1'b0}}) && (v_cnt_q == {YW{1'b0}});
`ifdef VIDEO_TIMING_TEST_PATTERN_EN
            if (h_vis_s && v_vis_s) begin
                rgb_d = bar_colour(h_cnt_q);
            end else begin
                rgb_d = 24'h000000;
            end
`endif
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = {XW{1'b0}};
                if (v_cnt_q == V_LAST) begin
                    v_cnt_d = {YW{1'b0}};
                end else begin
                    v_cnt_d = v_cnt_q + YW'(1);
                end
            end else begin
                h_cnt_d = h_cnt_q + XW'(1);
            end
        end else begin
            line_start_d  = 1'b0;
            frame_start_d = 1'b0;
        end
    end

    // State and output registers, reset to the inactive raster state.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            h_cnt_q       <= {XW{1'b0}};
            v_cnt_q       <= {YW{1'b0}};
            x_q           <= {XW{1'b0}};
            y_q           <= {YW{1'b0}};
            hsync_q       <= ~HS_ON;
            vsync_q       <= ~VS_ON;
            blanking_q    <= 1'b1;
            active_q      <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
`ifdef VIDEO_TIMING_TEST_PATTERN_EN
            rgb_q         <= 24'h000000;
`endif
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            x_q           <= x_d;
            y_q           <= y_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            blanking_q    <= blanking_d;
            active_q      <= active_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
`ifdef VIDEO_TIMING_TEST_PATTERN_EN
            rgb_q         <= rgb_d;
`endif
        end
    end

    assign vif.o_x            = x_q;
    assign vif.o_y            = y_q;
    assign vif.o_hsync        = hsync_q;
    assign vif.o_vsync        = vsync_q;
    assign vif.o_control_data = {vsync_q, hsync_q};
    assign vif.o_blanking     = blanking_q;
    assign vif.o_active       = active_q;
    assign vif.o_line_start   = line_start_q;
    assign vif.o_frame_start  = frame_start_q;
`ifdef VIDEO_TIMING_TEST_PATTERN_EN
    assign vif.o_rgb          = rgb_q;
`endif
endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Generates raster timing for the HDMI/DVI output path: a pixel/line counter pair plus decoded hsync, vsync, blanking and pixel coordinates.
- Sits directly upstream of the three tmds_gen encoders.
  - o_blanking drives their i_blanking.
  - o_control_data ({vsync,hsync}) drives i_control_data of the blue-channel encoder.
  - o_x/o_y go to the pixel source, typically the thermal frame-buffer reader.
- Default timing is 640x480@60 (25.175 MHz pixel clock).

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- H_SYNC_POL, 0, hsync active level (0 = active-low)
- V_SYNC_POL, 0, vsync active level (0 = active-low)

Ports:
- i_clk  in  1  pixel clock
- i_rst  in  1  asynchronous reset, active-high
- i_en  in  1  pixel-advance enable (tie 1 for a free-running pixel clock)
- o_hsync  out  1  horizontal sync, polarity per H_SYNC_POL
- o_vsync  out  1  vertical sync, polarity per V_SYNC_POL
- o_control_data  out  2  {o_vsync, o_hsync}, for the tmds_gen control input
- o_blanking  out  1  1 outside the active area
- o_active  out  1  equals ~o_blanking
- o_x  out  XW  horizontal count, XW = $clog2(H_TOTAL)
- o_y  out  YW  vertical count, YW = $clog2(V_TOTAL)
- o_line_start  out  1  one-cycle strobe at x==0
- o_frame_start  out  1  one-cycle strobe at x==0, y==0

Behaviour:
- Derived totals:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800)
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525)
- Internal counters h_cnt in 0..H_TOTAL-1 and v_cnt in 0..V_TOTAL-1; both reset to 0.
- Counter advance, on a rising edge with i_en=1:
  - h_cnt increments; at H_TOTAL-1 it wraps to 0 and v_cnt increments.
  - v_cnt wraps to 0 after V_TOTAL-1, on the same edge that h_cnt wraps.
- Region order per axis: active, front porch, sync, back porch.
  - hsync asserted for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC) = [656,752).
  - vsync asserted for whole lines v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC) = [490,492), independent of h_cnt.
  - Active area is h_cnt<H_ACTIVE && v_cnt<V_ACTIVE.
- All outputs are registered. On each enabled edge, the outputs load the decode of the pre-increment counter values. Pixel (x,y) therefore appears on the outputs one enabled edge after the counters hold (x,y).
- o_x/o_y are raw counter values: not clamped, and they span the blanking region.
- i_en=0:
  - Counters and all level outputs hold their values.
  - o_line_start and o_frame_start drop to 0, so each strobe lasts exactly one cycle.
- Reset values:
  - o_x=0, o_y=0
  - o_blanking=1, o_active=0
  - o_hsync=~H_SYNC_POL, o_vsync=~V_SYNC_POL (inactive levels)
  - o_control_data = {~V_SYNC_POL, ~H_SYNC_POL}
  - strobes=0
- Reset mid-frame: takes effect immediately (asynchronous). After release, the first enabled edge presents pixel (0,0), with o_frame_start=1 and o_line_start=1.
- Elaboration: assert that every porch/sync parameter is >=1 and each ACTIVE value is >=1.

Optional Feature:
- Macro: VIDEO_TIMING_TEST_PATTERN_EN.
- When defined, adds output o_rgb [23:0] ({R,G,B}), registered and aligned with o_x/o_y:
  - 8 vertical colour bars, each H_ACTIVE/8 pixels wide, in the order white, yellow, cyan, green, magenta, red, blue, black (full-scale 8'hFF/8'h00 components).
  - o_rgb=0 whenever blanking; reset value 0.
- When undefined, o_rgb does not exist and no pattern logic is built.

Test Plan:
- Reset held 4 cycles, then sampled before the first edge -> o_x=0, o_y=0, o_blanking=1, o_hsync=1, o_vsync=1, o_control_data=2'b11, strobes 0.
- Free-run one line -> o_blanking low for 640 consecutive cycles; o_hsync low for exactly 96 cycles starting at o_x=656; o_line_start period 800 cycles.
- Free-run a full frame -> o_frame_start period 420000 cycles; o_vsync low for exactly 1600 cycles (o_y 490..491); o_y wraps 524->0 together with o_x 799->0.
- i_en toggled 1,0,1,0 for 50 enabled edges -> outputs advance only on enabled edges; each strobe high for exactly one cycle; hsync timing measured in enabled edges matches the free-run case.
- Assert i_rst mid-frame (o_x=300, o_y=200) -> outputs return to reset values asynchronously; the first enabled edge after release gives o_x=0, o_y=0, o_frame_start=1.
- With VIDEO_TIMING_TEST_PATTERN_EN -> o_rgb=24'hFFFFFF at x=0, 24'hFFFF00 at x=80, 24'h000000 at x=639, 0 at x=700.
